// File: rtl/tinychip_pkg.sv
// Shared types and instruction-field layout for the TinyChip 9-bit ISA.
package tinychip_pkg;

  typedef enum logic [2:0] {
    OP_ADD      = 3'd0,
    OP_AND      = 3'd1,
    OP_BEQ      = 3'd2,
    OP_BNE      = 3'd3,
    OP_LW       = 3'd4,
    OP_SW       = 3'd5,
    OP_SRL      = 3'd6,
    OP_SLT_HALT = 3'd7
  } opcode_t;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam int INSN_W   = 9;
  localparam int IMM_BIT  = 8;
  localparam int OP_MSB   = 7;
  localparam int OP_LSB   = 5;
  localparam int RD_MSB   = 4;
  localparam int RD_LSB   = 3;
  localparam int RS_MSB   = 2;
  localparam int RS_LSB   = 1;
  localparam int IMM3_MSB = 2;
  localparam int IMM3_LSB = 0;

endpackage

// File: rtl/tinychip_insn_decode.sv
// Combinational field extraction and instruction classification.
module tinychip_insn_decode
  import tinychip_pkg::*;
(
  input  logic [INSN_W-1:0] instr,
  output opcode_t           op,
  output logic              imm_form,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [2:0]        imm3,
  output logic              is_branch,
  output logic              is_mem,
  output logic              is_halt,
  output logic              writes_rd
);

  assign op        = opcode_t'(instr[OP_MSB:OP_LSB]);
  assign imm_form  = instr[IMM_BIT];
  assign rd        = instr[RD_MSB:RD_LSB];
  assign rs        = instr[RS_MSB:RS_LSB];
  assign imm3      = instr[IMM3_MSB:IMM3_LSB];
  assign is_branch = (op == OP_BEQ) || (op == OP_BNE);
  assign is_mem    = (op == OP_LW) || (op == OP_SW);
  assign is_halt   = (op == OP_SLT_HALT) && imm_form;
  assign writes_rd = !(is_branch || (op == OP_SW) || is_halt);

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle TinyChip sequencer: fetch/decode/exec/mem/writeback over
// external instruction memory, register file and data memory handshakes.
module multicycle_controller
  import tinychip_pkg::*;
#(
  parameter int              DATA_W   = 8,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              instr_req,
  output logic [PC_W-1:0]   instr_addr,
  input  logic              instr_valid,
  input  logic [INSN_W-1:0] instr_data,
  output logic [1:0]        rf_raddr1,
  output logic [1:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [1:0]        rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              halted,
  output logic [15:0]       retired
);

  state_t                   state_q, state_d;
  logic [PC_W-1:0]          pc_q, pc_inc, pc_next;
  logic [15:0]              retired_q;
  logic                     pc_load, retire;
  logic [INSN_W-1:0]        instr_p0;
  logic signed [DATA_W-1:0] a_p1, b_p1;
  logic [DATA_W-1:0]        res_p2;
  logic [DATA_W-1:0]        imm_ext;
  logic                     br_taken;

  opcode_t    op;
  logic       imm_form, is_branch, is_mem, is_halt, writes_rd;
  logic [1:0] rd, rs;
  logic [2:0] imm3;

  function automatic logic [DATA_W-1:0] alu_op(input opcode_t fn,
                                               input logic signed [DATA_W-1:0] a,
                                               input logic signed [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (fn)
      OP_ADD:  r = a + b;
      OP_AND:  r = a & b;
      OP_SRL:  r = $unsigned(a) >> b[2:0];
      default: r = {{(DATA_W-1){1'b0}}, (a < b)};
    endcase
    return r;
  endfunction

  function automatic logic [PC_W-1:0] sext_pc(input logic signed [DATA_W-1:0] v);
    logic [PC_W+DATA_W-1:0] w;
    w = {{PC_W{v[DATA_W-1]}}, v};
    return w[PC_W-1:0];
  endfunction

  tinychip_insn_decode u_decode (
    .instr     (instr_p0),
    .op        (op),
    .imm_form  (imm_form),
    .rd        (rd),
    .rs        (rs),
    .imm3      (imm3),
    .is_branch (is_branch),
    .is_mem    (is_mem),
    .is_halt   (is_halt),
    .writes_rd (writes_rd)
  );

  assign imm_ext    = {{(DATA_W-3){1'b0}}, imm3};
  assign br_taken   = (op == OP_BEQ) ? (a_p1 == b_p1) : (a_p1 != b_p1);
  assign pc_inc     = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
  // Branch offset comes from R[3], read on port 1 during EXEC.
  assign pc_next    = (is_branch && br_taken) ? pc_q + sext_pc(rf_rdata1) : pc_inc;
  assign instr_addr = pc_q;
  assign retired    = retired_q;

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (instr_valid) state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (is_branch)      state_d = S_FETCH;
        else if (is_mem)    state_d = S_MEM;
        else if (writes_rd) state_d = S_WB;
        else                state_d = S_HALT;
      end
      S_MEM:    if (mem_ready) state_d = (op == OP_LW) ? S_WB : S_FETCH;
      S_WB:     state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    instr_req = 1'b0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    halted    = 1'b0;
    pc_load   = 1'b0;
    retire    = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH:  instr_req = 1'b1;
        S_DECODE: begin
          rf_raddr1 = rd;
          rf_raddr2 = rs;
        end
        S_EXEC: begin
          if (is_branch) begin
            rf_raddr1 = 2'd3;
            pc_load   = 1'b1;
            retire    = 1'b1;
          end else if (is_halt) begin
            retire = 1'b1;
          end
        end
        S_MEM: begin
          mem_req   = 1'b1;
          mem_we    = (op == OP_SW);
          mem_addr  = b_p1;
          mem_wdata = a_p1;
          if (mem_ready && (op == OP_SW)) begin
            pc_load = 1'b1;
            retire  = 1'b1;
          end
        end
        S_WB: begin
          rf_we    = 1'b1;
          rf_waddr = rd;
          rf_wdata = res_p2;
          pc_load  = 1'b1;
          retire   = 1'b1;
        end
        S_HALT:   halted = 1'b1;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      retired_q <= '0;
    end else begin
      if (pc_load) pc_q <= pc_next;
      if (retire)  retired_q <= retired_q + 16'd1;
    end
  end

  // p0: fetched word; p1: operands A/B; p2: ALU or load result
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH && instr_valid) instr_p0 <= instr_data;
    if (state_q == S_DECODE) begin
      a_p1 <= rf_rdata1;
      b_p1 <= imm_form ? imm_ext : rf_rdata2;
    end
    if (state_q == S_EXEC) res_p2 <= alu_op(op, a_p1, b_p1);
    if (state_q == S_MEM && mem_ready) res_p2 <= mem_rdata;
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench: an ISA-level reference model predicts fetch addresses,
// write-backs, memory accesses and latencies; a monitor checks DUT events.
module tb_multicycle_controller;
  localparam int DW     = 8;
  localparam int PW     = 10;
  localparam int PC_MOD = 1 << PW;
  localparam logic [PW-1:0] RP = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          instr_req;
  logic [PW-1:0] instr_addr;
  logic          instr_valid = 1'b0;
  logic [8:0]    instr_data = '0;
  logic [1:0]    rf_raddr1, rf_raddr2;
  logic [DW-1:0] rf_rdata1, rf_rdata2;
  logic          rf_we;
  logic [1:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          mem_req, mem_we;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          halted;
  logic [15:0]   retired;

  multicycle_controller #(.DATA_W(DW), .PC_W(PW), .RESET_PC(RP)) dut (
    .clk(clk), .reset(reset),
    .instr_req(instr_req), .instr_addr(instr_addr),
    .instr_valid(instr_valid), .instr_data(instr_data),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .halted(halted), .retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // External register file and data memory seen by the DUT
  logic [DW-1:0] rf [4];
  logic          pre_we = 1'b0;
  logic [1:0]    pre_addr = '0;
  logic [DW-1:0] pre_data = '0;
  always @(posedge clk) begin
    if (pre_we)     rf[pre_addr] <= pre_data;
    else if (rf_we) rf[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];
  logic [DW-1:0] dmem [256];

  // Reference model state
  int mdl_R [4];
  int mdl_mem [256];
  int mdl_pc;
  int mdl_ret;

  typedef struct { int addr; int data; } wb_t;
  typedef struct { bit we; int addr; int wdata; int held; } mem_t;
  int   exp_fetch [$];
  int   exp_lat [$];
  wb_t  exp_wb [$];
  mem_t exp_mem [$];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event with nothing expected", name);
  endtask

  function automatic int sx(input int v);
    return (v >= (1 << (DW-1))) ? v - (1 << DW) : v;
  endfunction

  task automatic push_wb(input int rd, input int val);
    wb_t w;
    w.addr = rd;
    w.data = val % (1 << DW);
    mdl_R[rd] = w.data;
    exp_wb.push_back(w);
  endtask

  // ISA semantics straight from the instruction definitions
  task automatic model_exec(input logic [8:0] ins, input int mw);
    int   imf  = int'(ins[8]);
    int   op   = int'(ins[7:5]);
    int   rd   = int'(ins[4:3]);
    int   rs   = int'(ins[2:1]);
    int   imm  = int'(ins[2:0]);
    int   a    = mdl_R[rd];
    int   b    = imf ? imm : mdl_R[rs];
    int   npc  = (mdl_pc + 1) % PC_MOD;
    int   base = 4;
    int   wait_c = 0;
    bit   halt = 0;
    mem_t m;
    case (op)
      0: push_wb(rd, a + b);
      1: push_wb(rd, a & b);
      2, 3: begin
        base = 3;
        if ((a == b) == (op == 2)) npc = (mdl_pc + sx(mdl_R[3])) & (PC_MOD - 1);
      end
      4: begin
        base = 5; wait_c = mw;
        m.we = 0; m.addr = b; m.wdata = 0; m.held = mw + 1;
        exp_mem.push_back(m);
        push_wb(rd, mdl_mem[b]);
      end
      5: begin
        wait_c = mw;
        m.we = 1; m.addr = b; m.wdata = a; m.held = mw + 1;
        exp_mem.push_back(m);
        mdl_mem[b] = a;
      end
      6: push_wb(rd, a >> (b % 8));
      default: begin
        if (imf != 0) halt = 1;
        else push_wb(rd, (sx(a) < sx(b)) ? 1 : 0);
      end
    endcase
    mdl_ret++;
    if (!halt) begin
      mdl_pc = npc;
      exp_fetch.push_back(npc);
      exp_lat.push_back(base + wait_c);
    end
  endtask

  task automatic set_reg(input int a, input int d);
    pre_we = 1'b1;
    pre_addr = a[1:0];
    pre_data = d[DW-1:0];
    @(posedge clk); #1;
    pre_we = 1'b0;
    mdl_R[a] = d % (1 << DW);
  endtask

  task automatic wait_fetch();
    int n = 0;
    while (!instr_req && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_req) fail_evt("fetch_timeout");
  endtask

  task automatic load_reg(input int a, input int d);
    wait_fetch();
    set_reg(a, d);
  endtask

  task automatic run_insn(input logic [8:0] ins, input int fw, input int mw);
    int n = 0;
    wait_fetch();
    check("retired", int'(retired), mdl_ret);
    repeat (fw) begin @(posedge clk); #1; end
    instr_valid = 1'b1;
    instr_data  = ins;
    model_exec(ins, mw);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    instr_data  = 9'($urandom);
    if (ins[7:6] == 2'b10) begin
      while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
      if (!mem_req) fail_evt("mem_req_timeout");
      repeat (mw) begin @(posedge clk); #1; end
      mem_ready = 1'b1;
      mem_rdata = dmem[mem_addr];
      if (mem_we) dmem[mem_addr] = mem_wdata;
      @(posedge clk); #1;
      mem_ready = 1'b0;
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents an event
  initial begin
    bit   prev_req = 0;
    bit   hs_ok = 0;
    int   hs_cyc = 0;
    int   mem_run = 0;
    wb_t  w;
    mem_t m;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_req = 0; hs_ok = 0; mem_run = 0;
        continue;
      end
      if (instr_req && !prev_req && hs_ok) begin
        hs_ok = 0;
        if (exp_lat.size() == 0) fail_evt("latency");
        else check("latency", cyc - hs_cyc, exp_lat.pop_front());
      end
      prev_req = instr_req;
      if (instr_req && instr_valid) begin
        if (exp_fetch.size() == 0) fail_evt("instr_addr");
        else check("instr_addr", int'(instr_addr), exp_fetch.pop_front());
        hs_ok = 1;
        hs_cyc = cyc;
      end
      if (mem_req) mem_run++;
      if (mem_req && mem_ready) begin
        if (exp_mem.size() == 0) fail_evt("mem_access");
        else begin
          m = exp_mem.pop_front();
          check("mem_we", int'(mem_we), int'(m.we));
          check("mem_addr", int'(mem_addr), m.addr);
          if (m.we) check("mem_wdata", int'(mem_wdata), m.wdata);
          check("mem_req_held", mem_run, m.held);
        end
        mem_run = 0;
      end else if (!mem_req) begin
        mem_run = 0;
      end
      if (rf_we) begin
        if (exp_wb.size() == 0) fail_evt("rf_we");
        else begin
          w = exp_wb.pop_front();
          check("rf_waddr", int'(rf_waddr), w.addr);
          check("rf_wdata", int'(rf_wdata), w.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] ins;
    int n;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'($urandom);
      mdl_mem[i] = int'(dmem[i]);
    end
    mdl_pc = int'(RP);
    mdl_ret = 0;
    for (int i = 0; i < 4; i++) set_reg(i, int'($urandom_range(0, 255)));
    check("rst_instr_req", int'(instr_req), 0);
    check("rst_mem_req", int'(mem_req), 0);
    check("rst_rf_we", int'(rf_we), 0);
    check("rst_halted", int'(halted), 0);
    check("rst_retired", int'(retired), 0);
    check("rst_instr_addr", int'(instr_addr), int'(RP));
    check("rst_mem_addr", int'(mem_addr), 0);
    exp_fetch.push_back(int'(RP));
    reset = 1'b0;

    // add immediate then register add
    load_reg(1, 0);
    run_insn(9'b1_000_01_101, 0, 0);
    run_insn(9'b0_000_01_01_0, 0, 0);
    wait_fetch();
    check("retired_two", int'(retired), 2);

    // signed compare and logical shift
    load_reg(1, 'h80);
    load_reg(2, 1);
    run_insn(9'b0_111_01_10_0, 1, 0);
    load_reg(1, 'h80);
    run_insn(9'b1_110_01_111, 0, 0);

    // branches: reach pc 10, back 2, fall through, wrap via 1023
    load_reg(3, (10 - mdl_pc) & 255);
    run_insn(9'b0_010_00_00_0, 0, 0);
    load_reg(3, 'hFE);
    run_insn(9'b0_010_00_00_0, 2, 0);
    run_insn(9'b0_011_00_00_0, 0, 0);
    load_reg(3, (-(mdl_pc + 1)) & 255);
    run_insn(9'b0_010_00_00_0, 0, 0);
    run_insn(9'b1_000_10_000, 0, 0);

    // store with wait states, then load it back
    run_insn(9'b1_101_10_011, 0, 2);
    run_insn(9'b1_100_01_011, 1, 2);

    for (int k = 0; k < 120; k++) begin
      ins = 9'($urandom);
      if (ins[7:5] == 3'b111) ins[8] = 1'b0;
      run_insn(ins, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
    end

    // reset while a store waits on mem_ready
    wait_fetch();
    instr_valid = 1'b1;
    instr_data  = 9'b1_101_10_011;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    n = 0;
    while (!mem_req && n < 10) begin @(posedge clk); #1; n++; end
    check("abort_mem_req_seen", int'(mem_req), 1);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check("abort_mem_req_drop", int'(mem_req), 0);
    exp_wb.delete(); exp_mem.delete(); exp_lat.delete(); exp_fetch.delete();
    mdl_pc = int'(RP);
    mdl_ret = 0;
    exp_fetch.push_back(int'(RP));
    @(posedge clk); #1;
    check("abort_mem_req", int'(mem_req), 0);
    check("abort_instr_addr", int'(instr_addr), int'(RP));
    check("abort_retired", int'(retired), 0);
    check("abort_rf_we", int'(rf_we), 0);
    reset = 1'b0;

    for (int k = 0; k < 10; k++) begin
      ins = 9'($urandom);
      if (ins[7:5] == 3'b111) ins[8] = 1'b0;
      run_insn(ins, int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    // HALT is absorbing and ignores fetch handshakes
    run_insn(9'b1_111_00_000, 0, 0);
    repeat (2) begin @(posedge clk); #1; end
    for (int k = 0; k < 12; k++) begin
      instr_valid = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      check("halt_halted", int'(halted), 1);
      check("halt_instr_req", int'(instr_req), 0);
      check("halt_mem_req", int'(mem_req), 0);
      check("halt_retired", int'(retired), mdl_ret);
    end
    instr_valid = 1'b0;

    check("left_fetch", exp_fetch.size(), 0);
    check("left_wb", exp_wb.size(), 0);
    check("left_mem", exp_mem.size(), 0);
    check("left_lat", exp_lat.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
